// File: rtl/fifo_sync_param_pkg.sv
// Shared defaults and helpers for the parametrised synchronous FIFO.
package fifo_sync_param_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_AFULL_TH  = 28;
  localparam int DEF_AEMPTY_TH = 4;

  // Pointers carry one extra wrap bit above the storage address.
  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// DEPTH x DATA_W storage: one synchronous write port, one registered read port.
module fifo_ram_dp
  import fifo_sync_param_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // NOTE: the array has no reset so it maps onto RAM primitives; the top masks
  // the read register until a word has actually been popped.
  always_ff @(posedge CLK) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// sticky overflow/underflow and synchronous flush.
module fifo_sync_param
  import fifo_sync_param_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AFULL_TH  = DEF_AFULL_TH,
  parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = ptr_w(ADDR_W);
  localparam logic [PTR_W-1:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] AFULL_C   = AFULL_TH[PTR_W-1:0];
  localparam logic [PTR_W-1:0] AEMPTY_C  = AEMPTY_TH[PTR_W-1:0];

  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic              r_rd_valid, r_rd_seen, r_overflow, r_underflow;
  logic              w_full, w_empty, w_push, w_pop;
  logic [DATA_W-1:0] w_ram_q;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                   (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);

  // Flush wins over both ports, so neither storage nor the read register moves.
  assign w_push = wr_en && !w_full  && !flush;
  assign w_pop  = rd_en && !w_empty && !flush;

  fifo_ram_dp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .CLK     (CLK),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr[ADDR_W-1:0]),
    .i_wdata (wr_data),
    .i_re    (w_pop),
    .i_raddr (r_rd_ptr[ADDR_W-1:0]),
    .o_rdata (w_ram_q)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, e.g. the full flag that gates a push.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_seen   <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_rd_valid <= w_pop;
      if (w_pop)              r_rd_seen   <= 1'b1;
      if (wr_en && w_full)    r_overflow  <= 1'b1;
      if (rd_en && w_empty)   r_underflow <= 1'b1;
    end
  end

  // Read data reads as zero from reset until the first accepted pop.
  assign rd_data      = r_rd_seen ? w_ram_q : '0;
  assign rd_valid     = r_rd_valid;
  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = r_wr_ptr - r_rd_ptr;
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: reference-queue scoreboard for popped
// data plus hand-computed checks of count, flags and sticky errors.
module tb_fifo_sync_param;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];

  fifo_sync_param #(.DATA_W(DW), .ADDR_W(AW), .AFULL_TH(28), .AEMPTY_TH(4)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .flush        (flush),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every presented word must match the oldest expected word.
  initial begin
    forever begin
      @(negedge CLK);
      if (RESET_N && rd_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rd_valid", 32'(rd_data), 32'hFFFF_FFFF);
        end else begin
          check("rd_data_order", 32'(rd_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Drive one cycle of stimulus; the reference queue predicts what is accepted
  // using the pre-edge occupancy.
  task automatic step(input logic wr, input logic [DW-1:0] wd, input logic rd, input logic fl);
    int sz;
    wr_en = wr; wr_data = wd; rd_en = rd; flush = fl;
    sz = model_q.size();
    if (fl) begin
      model_q.delete();
    end else begin
      if (rd && sz > 0)     exp_q.push_back(model_q.pop_front());
      if (wr && sz < DEPTH) model_q.push_back(wd);
    end
    @(posedge CLK);
    #2;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    int budget;

    // Reset state
    #12;
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_count", 32'(count), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_afull", 32'(almost_full), 0);
    check("rst_aempty", 32'(almost_empty), 1);
    check("rst_ovf_unf", 32'({overflow, underflow}), 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #2;

    // Fill 0x00..0x1F
    for (int i = 0; i < 32; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0);
      check("fill_count", 32'(count), i + 1);
      if (i == 3)  check("aempty_at4", 32'(almost_empty), 1);
      if (i == 4)  check("aempty_at5", 32'(almost_empty), 0);
      if (i == 26) check("afull_at27", 32'(almost_full), 0);
      if (i == 27) check("afull_at28", 32'(almost_full), 1);
      if (i == 30) check("full_at31", 32'(full), 0);
    end
    check("full_at32", 32'(full), 1);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    check("ovf_33rd", 32'(overflow), 1);
    check("count_33rd", 32'(count), 32);

    // Drain, with the one-cycle latency checked on the first pop
    step(1'b0, '0, 1'b1, 1'b0);
    check("lat_rd_valid", 32'(rd_valid), 1);
    check("lat_rd_data", 32'(rd_data), 32'h00);
    for (int i = 1; i < 32; i++) step(1'b0, '0, 1'b1, 1'b0);
    idle();
    check("drain_empty", 32'(empty), 1);
    check("drain_rd_valid", 32'(rd_valid), 0);
    check("ovf_sticky", 32'(overflow), 1);
    check("unf_clear", 32'(underflow), 0);

    // Wrap across the pointer MSB
    for (int i = 0; i < 20; i++) step(1'b1, 8'h40 + DW'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'h80 + DW'(i), 1'b0, 1'b0);
    check("wrap_count20", 32'(count), 20);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0);
    idle();
    check("wrap_empty", 32'(empty), 1);
    check("wrap_count0", 32'(count), 0);

    // Simultaneous push+pop at count 10
    for (int i = 0; i < 10; i++) step(1'b1, 8'hC0 + DW'(i), 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      step(1'b1, DW'(i), 1'b1, 1'b0);
      check("simul_count", 32'(count), 10);
    end
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);
    idle();
    check("simul_empty", 32'(empty), 1);

    // Empty edge
    step(1'b0, '0, 1'b1, 1'b0);
    check("pop_empty_unf", 32'(underflow), 1);
    check("pop_empty_valid", 32'(rd_valid), 0);
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    check("pushpop_empty_count", 32'(count), 1);
    check("pushpop_empty_valid", 32'(rd_valid), 0);
    step(1'b0, '0, 1'b1, 1'b0);
    idle();

    // Flush with a concurrent write at count 17
    for (int i = 0; i < 17; i++) step(1'b1, 8'h20 + DW'(i), 1'b0, 1'b0);
    check("pre_flush_count", 32'(count), 17);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    check("flush_count", 32'(count), 0);
    check("flush_empty", 32'(empty), 1);
    check("flush_ovf_unf", 32'({overflow, underflow}), 0);
    check("flush_rd_data_hold", 32'(rd_data), 32'h5A);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("post_flush_data", 32'(rd_data), 32'h77);
    idle();

    // Async reset mid-burst while popping and with overflow set
    for (int i = 0; i < 33; i++) step(1'b1, 8'h90 + DW'(i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("pre_rst_valid", 32'(rd_valid), 1);
    check("pre_rst_ovf", 32'(overflow), 1);
    RESET_N = 1'b0;
    #1;
    check("arst_empty", 32'(empty), 1);
    check("arst_count", 32'(count), 0);
    check("arst_rd_valid", 32'(rd_valid), 0);
    check("arst_ovf", 32'(overflow), 0);
    check("arst_rd_data", 32'(rd_data), 0);
    model_q.delete();
    exp_q.delete();
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #2;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    idle();

    // Let the monitor consume everything still outstanding
    budget = 0;
    while (exp_q.size() != 0 && budget < 10) begin
      @(posedge CLK);
      budget++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
